// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared types and helpers for the sram-like arbiter.
//   - SIZE_* access size encodings used on port_size
//   - tag_t: in-flight tag {valid, err, port index} carried by the latency pipeline
//   - size_addr_to_wen: byte-enable generation from wr/size/addr[1:0]
//   - is_misaligned: alignment check used when SRAM_ARB_MISALIGN_CHECK_EN is defined
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Port index width inside a tag; wide enough for the largest port count (4).
  localparam int IDX_W = 2;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Shift is evaluated in 4-bit context, so a half write at offset 3 keeps
  // only byte lane 3.
  function automatic logic [3:0] size_addr_to_wen(input logic       wr,
                                                  input logic [1:0] size,
                                                  input logic [1:0] lsb);
    logic [3:0] wen;
    case (size)
      SIZE_BYTE: wen = 4'b0001 << lsb;
      SIZE_HALF: wen = 4'b0011 << lsb;
      SIZE_WORD: wen = 4'b1111;
      default:   wen = 4'b1111;  // code 3 behaves as a word
    endcase
    return wr ? wen : 4'b0000;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lsb);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lsb[0];
      SIZE_WORD: mis = (lsb != 2'b00);
      default:   mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: bundle of the CPU-side sram-like ports and the
// shared SRAM port.
//   slave  modport: arbiter view (takes requests, drives the SRAM)
//   master modport: environment view (CPU masters plus the SRAM model)
// Per-port fields are packed arrays indexed by port number.
// port_err exists only when SRAM_ARB_MISALIGN_CHECK_EN is defined.
interface sram_like_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
);

  logic [NUM_PORTS-1:0]             port_req;
  logic [NUM_PORTS-1:0]             port_wr;
  logic [NUM_PORTS-1:0][1:0]        port_size;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
  logic [NUM_PORTS-1:0][31:0]       port_wdata;
  logic [NUM_PORTS-1:0]             port_addr_ok;
  logic [NUM_PORTS-1:0]             port_data_ok;
  logic [NUM_PORTS-1:0][31:0]       port_rdata;
`ifdef SRAM_ARB_MISALIGN_CHECK_EN
  logic [NUM_PORTS-1:0]             port_err;
`endif

  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  port_req, port_wr, port_size, port_addr, port_wdata,
    output port_addr_ok, port_data_ok, port_rdata,
`ifdef SRAM_ARB_MISALIGN_CHECK_EN
    output port_err,
`endif
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output port_req, port_wr, port_size, port_addr, port_wdata,
    input  port_addr_ok, port_data_ok, port_rdata,
`ifdef SRAM_ARB_MISALIGN_CHECK_EN
    input  port_err,
`endif
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_like_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, one grant per cycle.
//   clk, rst   : clock, async active-high reset (rr_ptr -> 0)
//   req        : per-port request
//   advance    : grant taken this cycle; moves rr_ptr past the winner
//   grant      : one-hot grant (zero when nothing requests)
//   grant_idx  : binary index of the granted port
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx
);

  logic [PORT_W-1:0] rr_ptr;
  logic [2:0]        k;
  logic              found;

  // Search from rr_ptr upward with wrap; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = 3'(rr_ptr) + 3'(i);
      if (k >= 3'(NUM_PORTS)) k = k - 3'(NUM_PORTS);
      if (!found && req[k[PORT_W-1:0]]) begin
        found                 = 1'b1;
        grant[k[PORT_W-1:0]] = 1'b1;
        grant_idx             = k[PORT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (advance && found)
      rr_ptr <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PORT_W'(1);
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one synchronous SRAM port among NUM_PORTS
// sram-like masters.
//   clk, rst : clock, async active-high reset
//   bus      : sram_like_arbiter_if.slave (per-port req/addr_ok/data_ok
//              handshake plus the SRAM en/wen/addr/wdata/rdata port)
// A granted request drives the SRAM in the same cycle; a LATENCY-deep tag
// pipeline (never stalls) returns data_ok to the issuing port exactly
// LATENCY cycles later, so responses come back in grant order.
// Optional: define SRAM_ARB_MISALIGN_CHECK_EN to suppress misaligned
// half/word accesses and flag them on port_err with their data_ok.
module sram_like_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_like_arbiter_if.slave bus
);
  import sram_like_pkg::*;

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    gidx;
  logic                 take;
  logic                 misalign;
  logic                 g_wr;
  logic [1:0]           g_size;
  logic [ADDR_W-1:0]    g_addr;

  // Nothing is accepted while reset is held, even with requests pending.
  assign take = (|bus.port_req) & ~rst;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.port_req),
    .advance   (take),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign g_wr   = bus.port_wr[gidx];
  assign g_size = bus.port_size[gidx];
  assign g_addr = bus.port_addr[gidx];

`ifdef SRAM_ARB_MISALIGN_CHECK_EN
  assign misalign = take & is_misaligned(g_size, g_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign bus.port_addr_ok = take ? grant : '0;
  assign bus.sram_en      = take & ~misalign;
  assign bus.sram_wen     = bus.sram_en ? size_addr_to_wen(g_wr, g_size, g_addr[1:0]) : 4'b0000;
  assign bus.sram_addr    = {g_addr[ADDR_W-1:2], 2'b00};
  assign bus.sram_wdata   = bus.port_wdata[gidx];

  // Tag pipeline: tag_q[0] is the tag of last cycle's grant,
  // tag_q[LATENCY-1] lines up with valid sram_rdata.
  tag_t               tag_in;
  tag_t [LATENCY-1:0] tag_q;
  tag_t               tag_out;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = take;
    tag_in.err   = misalign;
    tag_in.idx   = IDX_W'(gidx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tag_out = tag_q[LATENCY-1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    assign bus.port_data_ok[p] = tag_out.valid && (tag_out.idx == IDX_W'(p));
    assign bus.port_rdata[p]   = bus.sram_rdata;
`ifdef SRAM_ARB_MISALIGN_CHECK_EN
    assign bus.port_err[p]     = tag_out.valid && (tag_out.idx == IDX_W'(p)) && tag_out.err;
`endif
  end

`ifndef SRAM_ARB_MISALIGN_CHECK_EN
  logic unused_err;
  assign unused_err = tag_out.err;
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed self-checking bench for sram_like_arbiter.
// Two instances share clk/rst: u_dut1 (LATENCY=1) and u_dut3 (LATENCY=3).
// Each SRAM model returns {16'hC0DE, addr[15:0]} of the address it saw,
// delayed by that instance's latency. Inputs change 1ns after posedge,
// outputs are sampled on negedge.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32)) if1 ();
  sram_like_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32)) if3 ();

  sram_like_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .LATENCY(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );
  sram_like_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .LATENCY(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3)
  );

  logic [31:0]      rd1;
  logic [2:0][31:0] rd3;
  always @(posedge clk) begin
    rd1    <= {16'hC0DE, if1.sram_addr[15:0]};
    rd3[0] <= {16'hC0DE, if3.sram_addr[15:0]};
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign if1.sram_rdata = rd1;
  assign if3.sram_rdata = rd3[2];

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    if1.port_req = '0; if1.port_wr = '0; if1.port_size = '0; if1.port_addr = '0; if1.port_wdata = '0;
    if3.port_req = '0; if3.port_wr = '0; if3.port_size = '0; if3.port_addr = '0; if3.port_wdata = '0;
  endtask

  task automatic test_reset();
    if1.port_req = 2'b11; if1.port_wr = 2'b11; if1.port_size[0] = 2'd2; if1.port_size[1] = 2'd2;
    if3.port_req = 2'b01;
    settle();
    total++; if (if1.port_addr_ok !== 2'b00) begin bad++; $display("FAIL rst_addr_ok got=%b exp=00", if1.port_addr_ok); end
    total++; if (if1.sram_en !== 1'b0) begin bad++; $display("FAIL rst_sram_en got=%b exp=0", if1.sram_en); end
    total++; if (if1.sram_wen !== 4'b0000) begin bad++; $display("FAIL rst_sram_wen got=%b exp=0000", if1.sram_wen); end
    total++; if (if1.port_data_ok !== 2'b00) begin bad++; $display("FAIL rst_data_ok got=%b exp=00", if1.port_data_ok); end
    total++; if (if3.port_addr_ok !== 2'b00) begin bad++; $display("FAIL rst_addr_ok3 got=%b exp=00", if3.port_addr_ok); end
    total++; if (if3.port_data_ok !== 2'b00) begin bad++; $display("FAIL rst_data_ok3 got=%b exp=00", if3.port_data_ok); end
    step();
    idle_all();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    if1.port_req = 2'b01; if1.port_wr = 2'b00; if1.port_size[0] = 2'd2; if1.port_addr[0] = 32'h100;
    settle();
    total++; if (if1.port_addr_ok !== 2'b01) begin bad++; $display("FAIL rd_addr_ok got=%b exp=01", if1.port_addr_ok); end
    total++; if (if1.sram_en !== 1'b1) begin bad++; $display("FAIL rd_sram_en got=%b exp=1", if1.sram_en); end
    total++; if (if1.sram_addr !== 32'h100) begin bad++; $display("FAIL rd_sram_addr got=%h exp=100", if1.sram_addr); end
    total++; if (if1.sram_wen !== 4'b0000) begin bad++; $display("FAIL rd_sram_wen got=%b exp=0000", if1.sram_wen); end
    total++; if (if1.port_data_ok !== 2'b00) begin bad++; $display("FAIL rd_data_ok_early got=%b exp=00", if1.port_data_ok); end
    step();
    idle_all();
    settle();
    total++; if (if1.port_data_ok !== 2'b01) begin bad++; $display("FAIL rd_data_ok got=%b exp=01", if1.port_data_ok); end
    total++; if (if1.port_rdata[0] !== 32'hC0DE0100) begin bad++; $display("FAIL rd_rdata got=%h exp=c0de0100", if1.port_rdata[0]); end
    total++; if (if1.port_addr_ok !== 2'b00) begin bad++; $display("FAIL rd_addr_ok_idle got=%b exp=00", if1.port_addr_ok); end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    prev_g = 2'b00;
    if1.port_req = 2'b11; if1.port_wr = 2'b00;
    if1.port_size[0] = 2'd2; if1.port_size[1] = 2'd2;
    if1.port_addr[0] = 32'h10; if1.port_addr[1] = 32'h20;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      total++; if (if1.port_addr_ok !== exp_g) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, if1.port_addr_ok, exp_g); end
      total++; if (if1.port_data_ok !== prev_g) begin bad++; $display("FAIL rr_data_ok[%0d] got=%b exp=%b", i, if1.port_data_ok, prev_g); end
      if (prev_g == 2'b01) begin
        total++; if (if1.port_rdata[0] !== 32'hC0DE0010) begin bad++; $display("FAIL rr_rdata0[%0d] got=%h exp=c0de0010", i, if1.port_rdata[0]); end
      end else if (prev_g == 2'b10) begin
        total++; if (if1.port_rdata[1] !== 32'hC0DE0020) begin bad++; $display("FAIL rr_rdata1[%0d] got=%h exp=c0de0020", i, if1.port_rdata[1]); end
      end
      prev_g = exp_g;
      step();
    end
    idle_all();
    settle();
    total++; if (if1.port_data_ok !== 2'b10) begin bad++; $display("FAIL rr_data_ok_tail got=%b exp=10", if1.port_data_ok); end
    total++; if (if1.port_addr_ok !== 2'b00) begin bad++; $display("FAIL rr_addr_ok_tail got=%b exp=00", if1.port_addr_ok); end
    step();
  endtask

  task automatic test_write_bytes();
    if1.port_req = 2'b10; if1.port_wr = 2'b10;
    if1.port_size[1] = 2'd0; if1.port_addr[1] = 32'h203; if1.port_wdata[1] = 32'hEFEFEFEF;
    settle();
    total++; if (if1.port_addr_ok !== 2'b10) begin bad++; $display("FAIL sb_addr_ok got=%b exp=10", if1.port_addr_ok); end
    total++; if (if1.sram_wen !== 4'b1000) begin bad++; $display("FAIL sb_wen got=%b exp=1000", if1.sram_wen); end
    total++; if (if1.sram_addr !== 32'h200) begin bad++; $display("FAIL sb_addr got=%h exp=200", if1.sram_addr); end
    total++; if (if1.sram_wdata !== 32'hEFEFEFEF) begin bad++; $display("FAIL sb_wdata got=%h exp=efefefef", if1.sram_wdata); end
    step();
    if1.port_size[1] = 2'd1; if1.port_addr[1] = 32'h202; if1.port_wdata[1] = 32'h12341234;
    settle();
    total++; if (if1.port_addr_ok !== 2'b10) begin bad++; $display("FAIL sh_addr_ok got=%b exp=10", if1.port_addr_ok); end
    total++; if (if1.sram_wen !== 4'b1100) begin bad++; $display("FAIL sh_wen got=%b exp=1100", if1.sram_wen); end
    total++; if (if1.sram_addr !== 32'h200) begin bad++; $display("FAIL sh_addr got=%h exp=200", if1.sram_addr); end
    total++; if (if1.sram_wdata !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got=%h exp=12341234", if1.sram_wdata); end
    total++; if (if1.port_data_ok !== 2'b10) begin bad++; $display("FAIL sb_data_ok got=%b exp=10", if1.port_data_ok); end
    step();
    idle_all();
    settle();
    total++; if (if1.port_data_ok !== 2'b10) begin bad++; $display("FAIL sh_data_ok got=%b exp=10", if1.port_data_ok); end
    step();
  endtask

  task automatic test_wen_table();
    logic [1:0] sz [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    logic [1:0] lo [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [3:0] ew [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b1111, 4'b1111, 4'b1000, 4'b1111};
    int n = 6;
`ifndef SRAM_ARB_MISALIGN_CHECK_EN
    n = 8;  // misaligned rows: truncated half, ignored word offset
`endif
    for (int i = 0; i < n; i++) begin
      if1.port_req = 2'b01; if1.port_wr = 2'b01;
      if1.port_size[0] = sz[i]; if1.port_addr[0] = 32'h400 | 32'(lo[i]);
      settle();
      total++; if (if1.sram_wen !== ew[i]) begin bad++; $display("FAIL wen_tbl[%0d] got=%b exp=%b", i, if1.sram_wen, ew[i]); end
      total++; if (if1.sram_addr !== 32'h400) begin bad++; $display("FAIL wen_tbl_addr[%0d] got=%h exp=400", i, if1.sram_addr); end
      step();
    end
    idle_all();
  endtask

  task automatic test_latency3();
    logic [1:0] exp_ok;
    logic [1:0] exp_dok;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        if3.port_req = 2'b01; if3.port_wr = 2'b00; if3.port_size[0] = 2'd2;
        if3.port_addr[0] = 32'h300 + 32'(4 * i);
      end else begin
        idle_all();
      end
      settle();
      exp_ok  = (i < 4) ? 2'b01 : 2'b00;
      exp_dok = (i >= 3 && i <= 6) ? 2'b01 : 2'b00;
      total++; if (if3.port_addr_ok !== exp_ok) begin bad++; $display("FAIL l3_addr_ok[%0d] got=%b exp=%b", i, if3.port_addr_ok, exp_ok); end
      total++; if (if3.port_data_ok !== exp_dok) begin bad++; $display("FAIL l3_data_ok[%0d] got=%b exp=%b", i, if3.port_data_ok, exp_dok); end
      if (exp_dok == 2'b01) begin
        total++;
        if (if3.port_rdata[0] !== 32'hC0DE0300 + 32'(4 * (i - 3))) begin
          bad++; $display("FAIL l3_rdata[%0d] got=%h exp=%h", i, if3.port_rdata[0], 32'hC0DE0300 + 32'(4 * (i - 3)));
        end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    if3.port_req = 2'b01; if3.port_wr = 2'b00; if3.port_size[0] = 2'd2; if3.port_addr[0] = 32'h500;
    settle();
    total++; if (if3.port_addr_ok !== 2'b01) begin bad++; $display("FAIL mf_addr_ok got=%b exp=01", if3.port_addr_ok); end
    step();
    idle_all();
    rst = 1'b1;
    settle();
    total++; if (if3.port_data_ok !== 2'b00) begin bad++; $display("FAIL mf_data_ok_rst got=%b exp=00", if3.port_data_ok); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++; if (if3.port_data_ok !== 2'b00) begin bad++; $display("FAIL mf_data_ok[%0d] got=%b exp=00", i, if3.port_data_ok); end
      step();
    end
    // rr_ptr back at 0: port0 must win against port1
    if3.port_req = 2'b11; if3.port_size[0] = 2'd2; if3.port_size[1] = 2'd2;
    settle();
    total++; if (if3.port_addr_ok !== 2'b01) begin bad++; $display("FAIL mf_rr_ptr got=%b exp=01", if3.port_addr_ok); end
    step();
    idle_all();
  endtask

`ifdef SRAM_ARB_MISALIGN_CHECK_EN
  task automatic test_misalign();
    if1.port_req = 2'b01; if1.port_wr = 2'b01; if1.port_size[0] = 2'd2;
    if1.port_addr[0] = 32'h102; if1.port_wdata[0] = 32'hAABBCCDD;
    settle();
    total++; if (if1.port_addr_ok !== 2'b01) begin bad++; $display("FAIL mis_addr_ok got=%b exp=01", if1.port_addr_ok); end
    total++; if (if1.sram_en !== 1'b0) begin bad++; $display("FAIL mis_sram_en got=%b exp=0", if1.sram_en); end
    total++; if (if1.sram_wen !== 4'b0000) begin bad++; $display("FAIL mis_sram_wen got=%b exp=0000", if1.sram_wen); end
    step();
    if1.port_wr = 2'b00; if1.port_addr[0] = 32'h104;
    settle();
    total++; if (if1.port_data_ok !== 2'b01) begin bad++; $display("FAIL mis_data_ok got=%b exp=01", if1.port_data_ok); end
    total++; if (if1.port_err !== 2'b01) begin bad++; $display("FAIL mis_err got=%b exp=01", if1.port_err); end
    total++; if (if1.sram_en !== 1'b1) begin bad++; $display("FAIL al_sram_en got=%b exp=1", if1.sram_en); end
    step();
    idle_all();
    settle();
    total++; if (if1.port_data_ok !== 2'b01) begin bad++; $display("FAIL al_data_ok got=%b exp=01", if1.port_data_ok); end
    total++; if (if1.port_err !== 2'b00) begin bad++; $display("FAIL al_err got=%b exp=00", if1.port_err); end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_bytes();
    test_wen_table();
    test_latency3();
    test_reset_midflight();
`ifdef SRAM_ARB_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
